instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Fetch sequencer for the byte-addressed, big-endian instruction memory.
- The memory has a registered read: it samples read_address at posedge clk, and the 32-bit word is valid in the following cycle.
- This block owns the PC and issues word fetches. It tags each returned word with its PC, buffers up to two words, and hands them to decode over a valid/ready handshake.
- It also handles branch/jump redirects and halt.

Parameters:
- RESET_PC, 32'd0: PC loaded on reset. Bits [1:0] are ignored (forced 0).
- MEM_BYTES, 256: instruction memory size in bytes (power of 2). All PCs wrap modulo MEM_BYTES.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- read_address  output  32  fetch address to instruction memory. Registered; equal to the PC register.
- mem_instruction  input  32  memory read data, valid in the cycle after an issue.
- instr  output  32  head-of-buffer instruction.
- instr_pc  output  32  PC of instr.
- instr_valid  output  1  buffer non-empty.
- instr_ready  input  1  decode accepts instr this cycle.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  target PC. Bits [1:0] are forced 0.
- halt  input  1  level; suppresses new issues while high.

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, read_address=RESET_PC.
  - Buffer empty; instr_valid=0, instr=0, instr_pc=0.
  - inflight_q=0, inflight_pc_q=0.
  - Reset mid-operation discards the in-flight fetch and all buffered words immediately.
- Internal state:
  - pc_q: next fetch address.
  - inflight_q / inflight_pc_q: one outstanding fetch and its PC.
  - 2-entry FIFO of {pc, instr}: rd_ptr, wr_ptr, count in 0..2.
- pop = instr_valid & instr_ready.
- issue = !redirect_valid & !halt & (count + inflight_q - pop < 2).
- On issue:
  - inflight_q<=1, inflight_pc_q<=pc_q.
  - pc_q<=(pc_q+4) mod MEM_BYTES. Example: 252 -> 0 for MEM_BYTES=256.
  - Otherwise inflight_q<=0 and pc_q holds. read_address is stable; the memory's non-issue reads are ignored.
- Response: in any cycle with inflight_q=1 and no redirect, push {inflight_pc_q, mem_instruction} at cycle end.
- Latency and throughput:
  - Issue in cycle N -> instr_valid with that word in cycle N+2.
  - With instr_ready held high, 1 instruction/cycle sustained after the first.
- Redirect (priority over everything except reset), in cycle R:
  - Buffer flushed: count<=0, pointers reset.
  - The response arriving in R is dropped.
  - No issue in R; inflight_q<=0.
  - pc_q<=redirect_pc mod MEM_BYTES.
  - Fetch of the target issues in R+1 (unless halt); target instruction is valid in R+3.
  - A pop asserted in R is discarded: the head is flushed, not consumed.
- Halt:
  - No new issue while halt=1.
  - An in-flight fetch still completes into the buffer, and the buffer keeps draining to decode.
  - Deassertion resumes from pc_q the same cycle.
  - Redirect during halt still updates pc_q and flushes.
- Simultaneous push and pop: allowed at any count; count unchanged.
- Overflow is impossible by construction. Push while count=2 without pop is a bench assertion failure.
- Pop while empty is ignored.
- instr, instr_pc: driven from the FIFO head. They hold their last value when empty; only instr_valid qualifies them.

Test Plan:
- Reset, RESET_PC=0, memory preloaded at 0/4/8/12, instr_ready=1 -> read_address 0,4,8,12 on consecutive cycles. instr_valid first high 2 cycles after reset release, instr_pc=0,4,8,12 back-to-back with matching words.
- Backpressure: instr_ready=0 for 5 cycles after the first valid -> count saturates at 2 and issue stops, with read_address held at 8. On release, words 0,4 emit, then 8 follows with no loss or duplication.
- Redirect to 0x40 in a cycle with 2 buffered and 1 in flight -> instr_valid=0 next cycle. read_address=0x40 that cycle. First instr_pc after redirect is 0x40, 2 cycles later; no stale PCs are emitted.
- Wrap: redirect to 0xF8, MEM_BYTES=256 -> instr_pc sequence 0xF8, 0xFC, 0x00, 0x04.
- Halt asserted for 4 cycles during streaming -> in-flight word still delivered, no new read_address change. On release, fetching resumes at the next sequential PC.
- rst_n pulsed low mid-stream, not clock-aligned -> instr_valid=0 and read_address=RESET_PC immediately. After release the sequence restarts from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues word reads to a registered-read
// memory, tags returned words with their PC and queues up to two for decode.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] read_address,
  input  logic [31:0] mem_instruction,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  // Word-aligned address inside the memory window.
  localparam logic [31:0] ADDR_MASK  = 32'(MEM_BYTES - 1) & ~32'd3;
  localparam logic [31:0] RESET_PC_M = RESET_PC & ADDR_MASK;

  logic [31:0]       pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       inflight_pc_q, inflight_pc_d;
  logic [1:0][31:0]  fifo_pc_q, fifo_pc_d;
  logic [1:0][31:0]  fifo_instr_q, fifo_instr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic [2:0]        occupancy_s;

  // Handshake and issue decisions. Occupancy counts the word still in flight so
  // that a fetch is only launched when its response is guaranteed a free slot.
  always_comb begin
    pop_s       = (count_q != 2'd0) & instr_ready;
    push_s      = inflight_q & ~redirect_valid;
    occupancy_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s     = ~redirect_valid & ~halt & (occupancy_s < 3'd2);
  end

  // Next-state for PC, outstanding fetch and buffer.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_instr_d  = fifo_instr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (redirect_valid) begin
      // Flush wins over everything: the response and any pop this cycle are dropped.
      pc_d       = redirect_pc & ADDR_MASK;
      inflight_d = 1'b0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (issue_s) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = (pc_q + 32'd4) & ADDR_MASK;
      end else begin
        inflight_d    = 1'b0;
      end

      if (push_s) begin
        fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
        fifo_instr_d[wr_ptr_q] = mem_instruction;
        wr_ptr_d               = ~wr_ptr_q;
      end else begin
        wr_ptr_d               = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC_M;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      fifo_pc_q     <= '0;
      fifo_instr_q  <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_instr_q  <= fifo_instr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Outputs come straight from flops; head entry persists while the buffer is empty.
  always_comb begin
    read_address = pc_q;
    instr        = fifo_instr_q[rd_ptr_q];
    instr_pc     = fifo_pc_q[rd_ptr_q];
    instr_valid  = (count_q != 2'd0);
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed phases push expected PCs,
// a negedge monitor compares every word that decode actually accepts.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] read_address;
  logic [31:0] mem_instruction;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem_bytes [256];

  instr_fetch_ctrl #(.RESET_PC(32'd0), .MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .read_address(read_address),
    .mem_instruction(mem_instruction), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] byte_f(input logic [7:0] a);
    return 8'(a * 8'd37 + 8'd11);
  endfunction

  // Expected big-endian word at a PC, from the fill formula.
  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [7:0] b;
    b = pc[7:0];
    return {byte_f(b), byte_f(b + 8'd1), byte_f(b + 8'd2), byte_f(b + 8'd3)};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem_bytes[i] = byte_f(8'(i));
  end

  // Registered-read memory model.
  always @(posedge clk) begin
    mem_instruction <= {mem_bytes[read_address[7:0]],
                        mem_bytes[8'(read_address[7:0] + 8'd1)],
                        mem_bytes[8'(read_address[7:0] + 8'd2)],
                        mem_bytes[8'(read_address[7:0] + 8'd3)]};
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got pc %h expected none", instr_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check32("instr_pc", instr_pc, e);
        check32("instr", instr, exp_word(e));
      end
    end
    if (rst_n && dut.count_q == 2'd2 && dut.inflight_q && !redirect_valid && !instr_ready) begin
      n_total++;
      $display("FAIL overflow: got push at count 2 expected no push");
    end
  end

  initial begin
    rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'd0; halt = 1'b0;
    repeat (2) step();
    check32("rst_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst_addr", read_address, 32'd0);
    check32("rst_instr", instr, 32'd0);
    check32("rst_pc", instr_pc, 32'd0);

    // Streaming after reset
    exp_q.push_back(32'd0); exp_q.push_back(32'd4);
    exp_q.push_back(32'd8); exp_q.push_back(32'd12);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check32("p1_addr0", read_address, 32'd0);
    step();
    check32("p1_addr4", read_address, 32'd4);
    check32("p1_valid_e1", {31'd0, instr_valid}, 32'd0);
    step();
    check32("p1_addr8", read_address, 32'd8);
    check32("p1_valid_e2", {31'd0, instr_valid}, 32'd1);
    step();
    check32("p1_addr12", read_address, 32'd12);
    repeat (3) step();
    instr_ready = 1'b0;
    repeat (2) step();
    check32("p1_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure from a fresh reset
    rst_n = 1'b0;
    step();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    @(negedge clk); rst_n = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      if (i != 0) step();
      check32("bp_addr_hold", read_address, 32'd8);
      check32("bp_head_pc", instr_pc, 32'd0);
    end
    instr_ready = 1'b1;
    repeat (5) step();
    instr_ready = 1'b0;
    repeat (2) step();
    check32("bp_drained", 32'(exp_q.size()), 32'd0);

    // Redirect with a full buffer and a pop in the same cycle
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043; instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
    check32("rd_valid_flush", {31'd0, instr_valid}, 32'd0);
    check32("rd_addr", read_address, 32'h40);
    step();
    check32("rd_valid_r2", {31'd0, instr_valid}, 32'd0);
    step();
    check32("rd_first_pc", instr_pc, 32'h40);
    repeat (3) step();

    // Redirect while streaming, target wraps past the top of memory
    redirect_valid = 1'b1; redirect_pc = 32'h1234_56F8;
    step();
    redirect_valid = 1'b0;
    foreach (exp_q[i]) check32("rd_leftover", exp_q[i], 32'hFFFF_FFFF);
    exp_q.push_back(32'hF8); exp_q.push_back(32'hFC); exp_q.push_back(32'h00);
    exp_q.push_back(32'h04); exp_q.push_back(32'h08); exp_q.push_back(32'h0C);
    exp_q.push_back(32'h10); exp_q.push_back(32'h14); exp_q.push_back(32'h18);
    check32("wr_addr", read_address, 32'hF8);
    repeat (2) step();
    check32("wr_first_pc", instr_pc, 32'hF8);
    repeat (4) step();

    // Halt for four cycles mid-stream
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      check32("halt_addr", read_address, 32'h10);
    end
    check32("halt_empty", {31'd0, instr_valid}, 32'd0);
    step();
    halt = 1'b0;
    check32("resume_addr0", read_address, 32'h10);
    step();
    check32("resume_addr1", read_address, 32'h14);
    step();
    check32("resume_pc", instr_pc, 32'h10);
    repeat (3) step();

    // Asynchronous reset mid-stream
    #3 rst_n = 1'b0;
    #1;
    check32("arst_valid", {31'd0, instr_valid}, 32'd0);
    check32("arst_addr", read_address, 32'd0);
    check32("arst_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) step();
    @(posedge clk); #3 rst_n = 1'b1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    #1;
    check32("rr_addr0", read_address, 32'd0);
    step();
    check32("rr_addr4", read_address, 32'd4);
    step();
    check32("rr_first_pc", instr_pc, 32'd0);
    repeat (3) step();
    instr_ready = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check32("final_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
